// File: rtl/mic_level_pkg.sv
// Shared types and constants for the microphone level meter.
// FSM encoding, midscale/magnitude limits and LED bar thresholds.
package mic_level_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_CALC = 2'd1,
      ST_ACC  = 2'd2,
      ST_UPD  = 2'd3
   } state_t;

   localparam logic [11:0] MIDSCALE = 12'd2048;
   localparam logic [10:0] MAG_MAX  = 11'd2047;

   localparam logic [10:0] LED_THR [8] = '{
      11'd128,  11'd384,  11'd640,  11'd896,
      11'd1152, 11'd1408, 11'd1664, 11'd1920
   };

endpackage

// File: rtl/mic_abs_mag.sv
// Offset removal, absolute value and saturation of one mic sample.
// Result is registered when en is high (the meter's calc state).
module mic_abs_mag
   import mic_level_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [11:0] sample,
   output logic [10:0] mag
);

   logic signed [12:0] diff;
   logic        [12:0] absd;

   always_comb begin
      diff = $signed({1'b0, sample}) - $signed({1'b0, MIDSCALE});
      absd = diff[12] ? 13'(-diff) : 13'(diff);
   end

   // Only raw 0 yields 2048, which must clamp to the 11-bit range
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag <= '0;
      end else if (en) begin
         if (absd > 13'(MAG_MAX))
            mag <= MAG_MAX;
         else
            mag <= absd[10:0];
      end
   end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed peak-hold level meter with decay and LED bar.
// Optional clip indicator enabled by defining MIC_LEVEL_CLIP_EN.
module mic_level_meter
   import mic_level_pkg::*;
#(
   parameter int WINDOW       = 256,
   parameter int HOLD_WINDOWS = 8,
   parameter int DECAY_STEP   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [11:0] sample_data,
   output logic [10:0] level,
   output logic        level_valid,
   output logic [7:0]  led,
   output logic        clip
);

   localparam int CW = $clog2(WINDOW);
   localparam int HW = (HOLD_WINDOWS < 1) ? 1 :
                       $clog2(HOLD_WINDOWS + 1);

   state_t          state;
   state_t          state_nxt;
   logic [11:0]     samp;
   logic [10:0]     mag;
   logic [10:0]     win_max;
   logic [10:0]     decayed;
   logic [CW-1:0]   cnt;
   logic [HW-1:0]   hold_cnt;
   logic            win_end;

   assign win_end = (cnt == CW'(WINDOW - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_WAIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_WAIT: if (sample_valid) state_nxt = ST_CALC;
         ST_CALC: state_nxt = ST_ACC;
         ST_ACC:  state_nxt = win_end ? ST_UPD : ST_WAIT;
         ST_UPD:  state_nxt = ST_WAIT;
         default: state_nxt = ST_WAIT;
      endcase
   end

   mic_abs_mag u_mag (
      .clk    (clk),
      .rst    (rst),
      .en     (state == ST_CALC),
      .sample (samp),
      .mag    (mag)
   );

   always_comb begin
      decayed = '0;
      if (int'(level) > DECAY_STEP)
         decayed = level - 11'(DECAY_STEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp        <= '0;
         win_max     <= '0;
         cnt         <= '0;
         hold_cnt    <= '0;
         level       <= '0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= (state_nxt == ST_UPD);
         unique case (state)
            ST_WAIT: begin
               if (sample_valid)
                  samp <= sample_data;
            end
            ST_ACC: begin
               if (mag > win_max)
                  win_max <= mag;
               cnt <= cnt + 1'b1;
            end
            ST_UPD: begin
               win_max <= '0;
               cnt     <= '0;
               if (win_max >= level) begin
                  level    <= win_max;
                  hold_cnt <= HW'(HOLD_WINDOWS);
               end else if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else begin
                  level <= decayed;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led <= '0;
      end else begin
         for (int i = 0; i < 8; i++)
            led[i] <= (level >= LED_THR[i]);
      end
   end

`ifdef MIC_LEVEL_CLIP_EN
   logic [HW-1:0] clip_cnt;
   logic          clip_hit;

   assign clip_hit = (samp == 12'h000) || (samp == 12'hFFF);

   // Counter reloads on every clipping sample; expires at window ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clip     <= 1'b0;
         clip_cnt <= '0;
      end else if (state == ST_CALC && clip_hit) begin
         clip     <= 1'b1;
         clip_cnt <= HW'(HOLD_WINDOWS);
      end else if (state == ST_UPD && clip_cnt != '0) begin
         clip_cnt <= clip_cnt - 1'b1;
         if (clip_cnt == HW'(1))
            clip <= 1'b0;
      end
   end
`else
   assign clip = 1'b0;
`endif

endmodule

// File: tb/tb_mic_level_meter.sv
// Randomized scoreboard bench for mic_level_meter (WINDOW=4).
// Reference model tracks windows, hold, decay and clip in plain ints.
module tb_mic_level_meter;

   localparam int WIN  = 4;
   localparam int HOLD = 8;
   localparam int DEC  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [11:0] sample_data;
   logic [10:0] level;
   logic        level_valid;
   logic [7:0]  led;
   logic        clip;

   mic_level_meter #(
      .WINDOW       (WIN),
      .HOLD_WINDOWS (HOLD),
      .DECAY_STEP   (DEC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .level        (level),
      .level_valid  (level_valid),
      .led          (led),
      .clip         (clip)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int lvl;
      int ld;
      int cl;
      int stamp;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   int m_level, m_hold, m_ends;
   int w_max, w_cnt;
   bit w_clip;

   task automatic check(input string name,
                        input int act,
                        input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, req);
      end
   endtask

   function automatic int mag_of(input int s);
      int m;
      m = (s >= 2048) ? s - 2048 : 2048 - s;
      return (m > 2047) ? 2047 : m;
   endfunction

   function automatic int bar(input int l);
      int b;
      b = 0;
      for (int i = 0; i < 8; i++)
         if (l >= 128 + 256 * i) b = b | (1 << i);
      return b;
   endfunction

   task automatic model_reset();
      m_level = 0;
      m_hold  = 0;
      m_ends  = HOLD;
      w_max   = 0;
      w_cnt   = 0;
      w_clip  = 0;
   endtask

   task automatic end_window(input int stamp);
      exp_t e;
      if (w_max >= m_level) begin
         m_level = w_max;
         m_hold  = HOLD;
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         m_level = (m_level > DEC) ? m_level - DEC : 0;
      end
      if (w_clip) m_ends = 1;
      else if (m_ends < HOLD) m_ends++;
      e.lvl   = m_level;
      e.ld    = bar(m_level);
`ifdef MIC_LEVEL_CLIP_EN
      e.cl    = (m_ends < HOLD) ? 1 : 0;
`else
      e.cl    = 0;
`endif
      e.stamp = stamp;
      sb.push_back(e);
      w_max  = 0;
      w_cnt  = 0;
      w_clip = 0;
   endtask

   // Entered and left at #1 after a rising edge
   task automatic send(input int s,
                       input bit dbl,
                       input int extra);
      int st;
      int m;
      sample_data  = 12'(s);
      sample_valid = 1'b1;
      st = cyc;
      @(posedge clk); #1;
      if (dbl) begin
         sample_data = 12'h000;
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      m = mag_of(s);
      if (m > w_max) w_max = m;
      if (s == 0 || s == 4095) w_clip = 1;
      w_cnt++;
      if (w_cnt == WIN) end_window(st);
      repeat ((dbl ? 2 : 3) + extra) @(posedge clk);
      #1;
   endtask

   task automatic silent_windows(input int n);
      for (int w = 0; w < n; w++)
         for (int k = 0; k < WIN; k++)
            send(2048, 0, $urandom_range(0, 2));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (level_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_level_valid: got 1 expected 0");
            end else begin
               e = sb.pop_front();
               check("latency", cyc, e.stamp + 3);
               @(negedge clk);
               check("lv_pulse", int'(level_valid), 0);
               check("level", int'(level), e.lvl);
               check("clip", int'(clip), e.cl);
               @(negedge clk);
               check("led", int'(led), e.ld);
            end
         end
      end
   end

   initial begin : stim
      int s;
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_data  = 12'h000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_level", int'(level), 0);
      check("rst_led", int'(led), 0);
      check("rst_lv", int'(level_valid), 0);
      check("rst_clip", int'(clip), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      send(2048, 0, 0);
      send(2100, 0, 1);
      send(1948, 0, 0);
      send(2048, 0, 2);

      send(3000, 0, 0);
      send(2048, 0, 0);
      send(2048, 0, 0);
      send(2048, 0, 0);
      silent_windows(72);

      send(2098, 1, 0);
      send(2048, 0, 1);
      send(2048, 1, 0);
      send(2048, 0, 0);

      send(0, 0, 0);
      send(2048, 0, 0);
      send(2048, 0, 0);
      send(2048, 0, 0);
      silent_windows(10);

      for (int w = 0; w < 40; w++) begin
         for (int k = 0; k < WIN; k++) begin
            case ($urandom_range(0, 9))
               0: s = ($urandom_range(0, 1) == 1) ? 4095 : 0;
               1, 2, 3: s = $urandom_range(0, 4095);
               default: s = 2048 - 64 + $urandom_range(0, 128);
            endcase
            send(s, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3));
         end
      end

      send(3500, 0, 0);
      send(200, 0, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_led", int'(led), 0);
      check("mid_rst_lv", int'(level_valid), 0);
      check("mid_rst_clip", int'(clip), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send(2300, 0, 0);
      send(2048, 0, 0);
      send(1900, 0, 0);
      send(2048, 0, 3);
      silent_windows(3);

      for (int i = 0; i < 40 && sb.size() != 0; i++)
         @(posedge clk);
      check("drain", sb.size(), 0);
      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
